display_load_sequencer: RTL and testbench

Controller that owns the load port of the 4-character multiplexed column display. It accepts a 16-bit hex value (four 4-bit digits) over a valid/ready handshake and writes only the changed digits into the display, one per cycle. It then holds the load line low for a guaranteed minimum scan interval so the display keeps refreshing between updates. It also generates the display's synchronous active-high reset pulse after power-up.

---
 rtl/display_load_sequencer.sv | 156 +++++++++++++++
 tb/tb_display_load_sequencer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/display_load_sequencer.sv
// rtl/display_load_sequencer.sv - writes changed hex digits into a 4-char column display, then holds for a scan interval
module display_load_sequencer #(
  parameter int MIN_SCAN_CYCLES = 16,
  parameter int INIT_CYCLES     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value_in,
  input  logic        value_valid,
  output logic        value_ready,
  output logic [3:0]  disp_data,
  output logic [1:0]  disp_char_position,
  output logic        disp_load,
  output logic        disp_reset,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_LOAD,
    S_HOLD
  } state_t;

  localparam logic [3:0] INIT_LAST = 4'(INIT_CYCLES - 1);
  localparam logic [7:0] HOLD_LAST = 8'(MIN_SCAN_CYCLES - 1);

  state_t      state, state_d;
  logic [3:0]  init_cnt, init_cnt_d;
  logic [7:0]  hold_cnt, hold_cnt_d;
  logic [1:0]  pos, pos_d, pos_nxt;
  logic [15:0] latched, latched_d;
  logic [15:0] shadow, shadow_d;
  logic        shadow_valid, shadow_valid_d;
  logic [3:0]  changed, changed_d, new_changed;
  logic        value_ready_d, disp_load_d, disp_reset_d, busy_d;
  logic [3:0]  disp_data_d;
  logic [1:0]  disp_char_position_d;

  // Position 0 is the leftmost character, carried in the top nibble.
  function automatic logic [3:0] digit_of(input logic [15:0] v, input logic [1:0] p);
    case (p)
      2'd0:    digit_of = v[15:12];
      2'd1:    digit_of = v[11:8];
      2'd2:    digit_of = v[7:4];
      default: digit_of = v[3:0];
    endcase
  endfunction

  // Per-position change mask against what the display currently shows; all set when nothing shown yet.
  always_comb begin
    new_changed = 4'b0000;
    for (int p = 0; p < 4; p++) begin
      new_changed[p] = (digit_of(value_in, 2'(p)) != digit_of(shadow, 2'(p))) || !shadow_valid;
    end
  end

  // Next state and next (registered) output values.
  always_comb begin
    state_d              = state;
    init_cnt_d           = init_cnt;
    hold_cnt_d           = hold_cnt;
    pos_d                = pos;
    latched_d            = latched;
    shadow_d             = shadow;
    shadow_valid_d       = shadow_valid;
    changed_d            = changed;
    disp_data_d          = disp_data;
    disp_char_position_d = disp_char_position;
    disp_load_d          = 1'b0;
    pos_nxt              = pos + 2'd1;
    case (state)
      S_INIT: begin
        if (init_cnt == INIT_LAST) begin
          state_d = S_IDLE;
        end else begin
          init_cnt_d = init_cnt + 4'd1;
        end
      end
      S_IDLE: begin
        if (value_valid && value_ready) begin
          latched_d            = value_in;
          changed_d            = new_changed;
          pos_d                = 2'd0;
          state_d              = S_LOAD;
          disp_char_position_d = 2'd0;
          disp_data_d          = value_in[15:12];
          disp_load_d          = new_changed[0];
        end
      end
      S_LOAD: begin
        if (pos == 2'd3) begin
          shadow_d       = latched;
          shadow_valid_d = 1'b1;
          if (|changed) begin
            state_d    = S_HOLD;
            hold_cnt_d = 8'd0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          pos_d                = pos_nxt;
          disp_char_position_d = pos_nxt;
          disp_data_d          = digit_of(latched, pos_nxt);
          disp_load_d          = changed[pos_nxt];
        end
      end
      default: begin
        if (hold_cnt == HOLD_LAST) begin
          state_d = S_IDLE;
        end else begin
          hold_cnt_d = hold_cnt + 8'd1;
        end
      end
    endcase
    disp_reset_d  = (state_d == S_INIT);
    value_ready_d = (state_d == S_IDLE);
    busy_d        = (state_d != S_IDLE);
  end

  // State, datapath and output registers; reset takes effect without waiting for clk.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state              <= S_INIT;
      init_cnt           <= 4'd0;
      hold_cnt           <= 8'd0;
      pos                <= 2'd0;
      latched            <= 16'h0000;
      shadow             <= 16'h0000;
      shadow_valid       <= 1'b0;
      changed            <= 4'b0000;
      value_ready        <= 1'b0;
      disp_load          <= 1'b0;
      disp_data          <= 4'd0;
      disp_char_position <= 2'd0;
      disp_reset         <= 1'b1;
      busy               <= 1'b1;
    end else begin
      state              <= state_d;
      init_cnt           <= init_cnt_d;
      hold_cnt           <= hold_cnt_d;
      pos                <= pos_d;
      latched            <= latched_d;
      shadow             <= shadow_d;
      shadow_valid       <= shadow_valid_d;
      changed            <= changed_d;
      value_ready        <= value_ready_d;
      disp_load          <= disp_load_d;
      disp_data          <= disp_data_d;
      disp_char_position <= disp_char_position_d;
      disp_reset         <= disp_reset_d;
      busy               <= busy_d;
    end
  end

endmodule

// File: tb/tb_display_load_sequencer.sv
// tb/tb_display_load_sequencer.sv - self-checking bench for display_load_sequencer
module tb_display_load_sequencer;

  localparam int MIN_SCAN = 16;

  logic        clk;
  logic        reset;
  logic [15:0] value_in;
  logic        value_valid;
  logic        value_ready;
  logic [3:0]  disp_data;
  logic [1:0]  disp_char_position;
  logic        disp_load;
  logic        disp_reset;
  logic        busy;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [15:0] value;
    logic [3:0]  mask;   // bit 3 = position 0 ... bit 0 = position 3
  } vec_t;

  vec_t vecs[7];

  display_load_sequencer #(.MIN_SCAN_CYCLES(MIN_SCAN), .INIT_CYCLES(2)) dut (
    .clk                (clk),
    .reset              (reset),
    .value_in           (value_in),
    .value_valid        (value_valid),
    .value_ready        (value_ready),
    .disp_data          (disp_data),
    .disp_char_position (disp_char_position),
    .disp_load          (disp_load),
    .disp_reset         (disp_reset),
    .busy               (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] pack(input logic [1:0] p, input logic [3:0] d, input logic ld,
                                       input logic rdy, input logic bsy, input logic rst);
    return {6'd0, p, d, ld, rdy, bsy, rst};
  endfunction

  function automatic logic [15:0] obs();
    return pack(disp_char_position, disp_data, disp_load, value_ready, busy, disp_reset);
  endfunction

  function automatic logic [3:0] dig(input logic [15:0] v, input int p);
    logic [15:0] t;
    t = v >> (12 - 4 * p);
    return t[3:0];
  endfunction

  // Called at the negedge following the handshake edge.
  task automatic check_burst(input logic [15:0] v, input logic [3:0] mask, input bit scramble);
    for (int p = 0; p < 4; p++) begin
      check($sformatf("load_p%0d_%h", p, v), obs(), pack(2'(p), dig(v, p), mask[3-p], 1'b0, 1'b1, 1'b0));
      if (scramble) value_in = 16'($urandom);
      else value_valid = 1'b0;
      @(negedge clk);
    end
    if (mask != 4'b0000) begin
      for (int k = 0; k < MIN_SCAN; k++) begin
        check($sformatf("hold_%0d_%h", k, v), obs(), pack(2'd3, dig(v, 3), 1'b0, 1'b0, 1'b1, 1'b0));
        if (scramble) value_in = 16'($urandom);
        @(negedge clk);
      end
    end
    check($sformatf("ready_back_%h", v), {13'd0, value_ready, busy, disp_load}, 16'b100);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (value_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", {15'd0, value_ready}, 16'd1);
  endtask

  task automatic send(input logic [15:0] v, input logic [3:0] mask);
    wait_ready();
    value_in    = v;
    value_valid = 1'b1;
    @(negedge clk);
    value_valid = 1'b0;
    value_in    = ~v;
    check_burst(v, mask, 1'b0);
  endtask

  task automatic init_sequence(input string tag);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check({tag, "_init0"}, obs(), pack(2'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1));
    @(negedge clk);
    check({tag, "_init1"}, obs(), pack(2'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1));
    @(negedge clk);
    check({tag, "_idle"}, obs(), pack(2'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0));
  endtask

  initial begin
    vecs[0] = '{16'h1234, 4'b1111};
    vecs[1] = '{16'h1F34, 4'b0100};
    vecs[2] = '{16'h1F34, 4'b0000};
    vecs[3] = '{16'hABCD, 4'b1111};
    vecs[4] = '{16'hAB0D, 4'b0010};
    vecs[5] = '{16'h0B0D, 4'b1000};
    vecs[6] = '{16'h0B0E, 4'b0001};

    value_in    = 16'h0000;
    value_valid = 1'b0;
    reset       = 1'b1;
    #1 reset    = 1'b0;

    // Power-up
    @(negedge clk);
    check("reset_state", obs(), pack(2'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1));
    repeat (2) @(negedge clk);
    init_sequence("pwr");

    // Table of handshakes
    for (int i = 0; i < 7; i++) begin
      send(vecs[i].value, vecs[i].mask);
    end

    // value_valid held with value_in churning during LOAD/HOLD
    wait_ready();
    value_in    = 16'h2222;
    value_valid = 1'b1;
    @(negedge clk);
    check_burst(16'h2222, 4'b1111, 1'b1);
    value_in = 16'h2299;
    @(negedge clk);
    check_burst(16'h2299, 4'b0011, 1'b0);

    // Reset asserted during position 1 of a burst
    wait_ready();
    value_in    = 16'h0B0E;
    value_valid = 1'b1;
    @(negedge clk);
    value_valid = 1'b0;
    check("mid_p0", obs(), pack(2'd0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0));
    @(negedge clk);
    check("mid_p1", obs(), pack(2'd1, 4'hB, 1'b1, 1'b0, 1'b1, 1'b0));
    #2 reset = 1'b0;
    #1;
    check("async_reset", obs(), pack(2'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1));
    repeat (2) @(posedge clk);
    init_sequence("mid");
    send(16'h2299, 4'b1111);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
